// File: rtl/cpu_bram_arbiter.sv
// cpu_bram_arbiter: two-port round-robin arbiter for one single-port byte-enabled BRAM
module cpu_bram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [DATA_W/8-1:0]   be0,
  input  logic [DATA_W/8-1:0]   be1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_W-1:0]     rdata0,
  output logic [DATA_W-1:0]     rdata1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteena,
  output logic [DATA_W-1:0]     mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_W-1:0]     mem_q
);
  logic                  r_last;
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY-1:0] r_tag;
  logic                  w_any;
  logic                  w_sel;
  logic                  w_we;
  always_comb begin
    w_any       = ~aclr & (req0 | req1);
    w_sel       = (req0 & req1) ? ~r_last : req1;
    w_we        = w_sel ? we1 : we0;
    gnt0        = w_any & ~w_sel;
    gnt1        = w_any & w_sel;
    mem_wren    = w_any & w_we;
    mem_rden    = w_any & ~w_we;
    mem_address = w_any ? (w_sel ? addr1 : addr0) : '0;
    mem_byteena = !w_any ? '0 : w_we ? (w_sel ? be1 : be0) : '1;
    mem_data    = mem_wren ? (w_sel ? wdata1 : wdata0) : '0;
  end
  // each stage carries {valid, port}; the last stage lines up with mem_q
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_last <= 1'b1;
      r_vld  <= '0;
      r_tag  <= '0;
    end else begin
      if (w_any) r_last <= w_sel;
      r_vld[0] <= mem_rden;
      r_tag[0] <= w_sel;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end
  always_comb begin
    rvalid0 = r_vld[RD_LATENCY-1] & ~r_tag[RD_LATENCY-1];
    rvalid1 = r_vld[RD_LATENCY-1] & r_tag[RD_LATENCY-1];
    rdata0  = mem_q;
    rdata1  = mem_q;
  end
endmodule

// File: tb/tb_cpu_bram_arbiter.sv
// tb_cpu_bram_arbiter: scoreboard bench with a BRAM model and a round-robin reference model
module tb_cpu_bram_arbiter;
  localparam int AW = 16, DW = 32, BW = 4, L = 1;
  logic clock = 0, aclr = 1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [BW-1:0] be0 = 0, be1 = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_rden, mem_wren;
  logic [DW-1:0] rdata0, rdata1, mem_data, mem_q;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteena;
  always #5 clock = ~clock;
  cpu_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) dut (
    .clock(clock), .aclr(aclr), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_address(mem_address), .mem_byteena(mem_byteena),
    .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q));
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] qp [L];
  always @(posedge clock) begin
    if (mem_wren)
      for (int i = 0; i < BW; i++)
        if (mem_byteena[i]) bram[mem_address][8*i+:8] <= mem_data[8*i+:8];
    if (mem_rden) qp[0] <= bram[mem_address];
    for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
  end
  assign mem_q = qp[L-1];
  typedef struct {int port; logic [DW-1:0] data; int due;} exp_t;
  exp_t sb[$];
  int cyc = 0, tests = 0, fails = 0, pref = 0;
  initial
    for (int a = 0; a < (1 << AW); a++) begin
      bram[a] = {16'hC0DE, a[15:0]};
      ref_mem[a] = {16'hC0DE, a[15:0]};
    end
  // checker: read-return monitor, then grant/bus check and model update
  initial forever begin
    logic [1:0] erv, eg;
    logic [DW-1:0] ed, eaddr_d, edat;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    logic any, ewe;
    int w;
    @(negedge clock);
    cyc++;
    if (aclr) begin
      sb.delete();
      pref = 0;
    end
    erv = 2'b00;
    ed = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      erv = sb[0].port ? 2'b10 : 2'b01;
      ed = sb[0].data;
      void'(sb.pop_front());
    end
    tests++;
    if ({rvalid1, rvalid0} !== erv || (erv != 0 && (erv[0] ? rdata0 : rdata1) !== ed)) begin
      fails++;
      $display("FAIL rvalid cyc=%0d got rv=%b d0=%h d1=%h expected rv=%b d=%h",
               cyc, {rvalid1, rvalid0}, rdata0, rdata1, erv, ed);
    end
    any = !aclr && (req0 || req1);
    w = (req0 && req1) ? pref : (req1 ? 1 : 0);
    ewe = w ? we1 : we0;
    eg = !any ? 2'b00 : (w ? 2'b10 : 2'b01);
    ea = any ? (w ? addr1 : addr0) : '0;
    eb = !any ? '0 : ewe ? (w ? be1 : be0) : 4'hF;
    edat = (any && ewe) ? (w ? wdata1 : wdata0) : '0;
    eaddr_d = {16'h0, ea};
    tests++;
    if ({gnt1, gnt0} !== eg || mem_rden !== (any && !ewe) || mem_wren !== (any && ewe) ||
        mem_address !== ea || mem_byteena !== eb || mem_data !== edat) begin
      fails++;
      $display("FAIL grant cyc=%0d got gnt=%b rd=%b wr=%b a=%h be=%h d=%h expected gnt=%b rd=%b wr=%b a=%h be=%h d=%h",
               cyc, {gnt1, gnt0}, mem_rden, mem_wren, mem_address, mem_byteena, mem_data,
               eg, any && !ewe, any && ewe, eaddr_d[AW-1:0], eb, edat);
    end
    if (any) begin
      pref = 1 - w;
      if (ewe) begin
        for (int i = 0; i < BW; i++)
          if (eb[i]) ref_mem[ea][8*i+:8] = edat[8*i+:8];
      end else sb.push_back('{w, ref_mem[ea], cyc + L});
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic setp(int p, bit r, bit w, logic [AW-1:0] a, logic [BW-1:0] b, logic [DW-1:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; be0 = b; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; be1 = b; wdata1 = d;
    end
  endtask
  task automatic reset_pulse();
    aclr = 1;
    step();
    step();
    aclr = 0;
  endtask
  initial begin
    logic g0, g1;
    step();
    step();
    aclr = 0;
    setp(0, 1, 1, 16'h0003, 4'hF, 32'hA0000003);
    step();
    setp(0, 1, 0, 16'h0003, 4'h0, 32'h0);
    step();
    setp(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    reset_pulse();
    setp(0, 1, 0, 16'h0001, 0, 0);
    setp(1, 1, 0, 16'h0002, 0, 0);
    repeat (6) step();
    setp(0, 0, 0, 0, 0, 0);
    setp(1, 1, 1, 16'h000B, 4'hF, 32'hFFFFFFFF);
    step();
    setp(1, 1, 1, 16'h000B, 4'b1100, 32'h1234ABCD);
    step();
    setp(1, 1, 0, 16'h000B, 0, 0);
    step();
    setp(1, 0, 0, 0, 0, 0);
    repeat (2) step();
    setp(0, 1, 0, 16'h0005, 0, 0);
    step();
    setp(0, 1, 0, 16'h000A, 0, 0);
    setp(1, 1, 1, 16'h000A, 4'hF, 32'hDEADBEEF);
    step();
    setp(1, 0, 0, 0, 0, 0);
    step();
    setp(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    setp(0, 1, 0, 16'h0007, 0, 0);
    step();
    setp(0, 0, 0, 0, 0, 0);
    reset_pulse();
    setp(0, 1, 0, 16'h0001, 0, 0);
    setp(1, 1, 0, 16'h0002, 0, 0);
    repeat (3) step();
    setp(0, 0, 0, 0, 0, 0);
    setp(1, 0, 0, 0, 0, 0);
    repeat (10) step();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      g0 = gnt0;
      g1 = gnt1;
      step();
      if (!req0 || g0)
        setp(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 16'($urandom_range(0, 15)),
             4'($urandom), $urandom);
      if (!req1 || g1)
        setp(1, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 16'($urandom_range(0, 15)),
             4'($urandom), $urandom);
    end
    @(negedge clock);
    g0 = gnt0;
    g1 = gnt1;
    step();
    setp(0, 0, 0, 0, 0, 0);
    setp(1, 0, 0, 0, 0, 0);
    repeat (L + 3) step();
    @(negedge clock);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending reads, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
